// File: rtl/led_blink_pkg.sv
// Shared types for the LED blink bank: channel mode encoding and address width helper.
package led_blink_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    PWM   = 2'd3
  } mode_t;

  function automatic int aw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_blink_if.sv
// Configuration write port of the LED blink bank: one-cycle write strobe plus ack/err pulses.
interface led_blink_if
  import led_blink_pkg::*;
#(
  parameter int AW    = 2,
  parameter int CNT_W = 24
);
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  mode_t            cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_duty;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_mode, cfg_period, cfg_duty,
    input  cfg_ack, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_mode, cfg_period, cfg_duty,
    output cfg_ack, cfg_err
  );
endinterface

// File: rtl/led_blink_ch.sv
// One LED channel: tick-driven wrap counter, blink-state bit, config registers and LED decode.
module led_blink_ch
  import led_blink_pkg::*;
#(
  parameter int    CNT_W      = 24,
  parameter int    RST_PERIOD = (1 << 23) - 1,
  parameter mode_t RST_MODE   = BLINK
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             i_tick,
  input  logic             i_wr,
  input  mode_t            i_mode,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_led
);
  mode_t            r_mode;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] r_cnt;
  logic             r_blink;
  logic             w_wrap;

  assign w_wrap = i_tick && (r_cnt == r_period);

  // A write takes priority over a coincident wrap: counter restarts, no toggle.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_mode   <= RST_MODE;
      r_period <= CNT_W'(RST_PERIOD);
      r_duty   <= '0;
      r_cnt    <= '0;
      r_blink  <= 1'b1;
    end else if (i_wr) begin
      r_mode   <= i_mode;
      r_period <= i_period;
      r_duty   <= i_duty;
      r_cnt    <= '0;
      r_blink  <= 1'b1;
    end else if (w_wrap) begin
      r_cnt    <= '0;
      r_blink  <= ~r_blink;
    end else if (i_tick) begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    o_led = 1'b0;
    unique case (r_mode)
      OFF:     o_led = 1'b0;
      ON:      o_led = 1'b1;
      BLINK:   o_led = r_blink;
      PWM:     o_led = (r_cnt < r_duty);
      default: o_led = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_blink_bank.sv
// Bank of LED channels sharing one prescaler; decodes config writes onto the addressed channel.
module led_blink_bank
  import led_blink_pkg::*;
#(
  parameter int    CH         = 4,
  parameter int    CNT_W      = 24,
  parameter int    PRE_DIV    = 1,
  parameter int    RST_PERIOD = (1 << 23) - 1,
  parameter mode_t RST_MODE   = BLINK
) (
  input  logic          m_clock,
  input  logic          p_reset,
  led_blink_if.slave    cfg,
  output logic          tick,
  output logic [CH-1:0] led
);
  localparam int AW = aw_f(CH);
  localparam int PW = aw_f(PRE_DIV);

  logic [PW-1:0] r_pre;
  logic          r_ack;
  logic          r_err;
  logic          w_addr_ok;

  assign tick      = (r_pre == PW'(PRE_DIV - 1));
  assign w_addr_ok = (32'(cfg.cfg_addr) < 32'(CH));

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset)  r_pre <= '0;
    else if (tick) r_pre <= '0;
    else           r_pre <= r_pre + 1'b1;
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= cfg.cfg_we &&  w_addr_ok;
      r_err <= cfg.cfg_we && !w_addr_ok;
    end
  end

  assign cfg.cfg_ack = r_ack;
  assign cfg.cfg_err = r_err;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic w_wr;
    assign w_wr = cfg.cfg_we && (cfg.cfg_addr == AW'(gi));

    led_blink_ch #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (RST_PERIOD),
      .RST_MODE   (RST_MODE)
    ) u_ch (
      .m_clock  (m_clock),
      .p_reset  (p_reset),
      .i_tick   (tick),
      .i_wr     (w_wr),
      .i_mode   (cfg.cfg_mode),
      .i_period (cfg.cfg_period),
      .i_duty   (cfg.cfg_duty),
      .o_led    (led[gi])
    );
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// Randomised bench for led_blink_bank against a tick-count reference model, plus fixed timing checks.
module tb_led_blink_bank;
  import led_blink_pkg::*;

  localparam int CH = 3;
  localparam int CNT_W = 8;
  localparam int PRE_DIV = 4;
  localparam int RST_PERIOD = 3;

  logic m_clock = 1'b0;
  logic p_reset;
  logic tick;
  logic [CH-1:0] led;

  led_blink_if #(.AW(2), .CNT_W(CNT_W)) cfg ();

  led_blink_bank #(
    .CH(CH), .CNT_W(CNT_W), .PRE_DIV(PRE_DIV),
    .RST_PERIOD(RST_PERIOD), .RST_MODE(BLINK)
  ) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .cfg     (cfg.slave),
    .tick    (tick),
    .led     (led)
  );

  always #5 m_clock = ~m_clock;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: each channel is described by the number of ticks since its last
  // write/reset; counter and blink state follow from division by (period+1).
  int    k;
  int    n     [CH];
  mode_t m_mode[CH];
  int    m_per [CH];
  int    m_duty[CH];
  bit    m_ack, m_err;

  always @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      k <= 0;
      m_ack <= 1'b0;
      m_err <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        n[i] <= 0; m_mode[i] <= BLINK; m_per[i] <= RST_PERIOD; m_duty[i] <= 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (cfg.cfg_we && int'(cfg.cfg_addr) == i) begin
          n[i] <= 0;
          m_mode[i] <= cfg.cfg_mode;
          m_per[i]  <= int'(cfg.cfg_period);
          m_duty[i] <= int'(cfg.cfg_duty);
        end else if ((k % PRE_DIV) == PRE_DIV - 1) begin
          n[i] <= n[i] + 1;
        end
      end
      m_ack <= cfg.cfg_we && (int'(cfg.cfg_addr) < CH);
      m_err <= cfg.cfg_we && (int'(cfg.cfg_addr) >= CH);
      k <= k + 1;
    end
  end

  function automatic logic [CH-1:0] exp_led();
    logic [CH-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) begin
      int p, c, w;
      p = m_per[i] + 1;
      c = n[i] % p;
      w = n[i] / p;
      case (m_mode[i])
        OFF:     v[i] = 1'b0;
        ON:      v[i] = 1'b1;
        BLINK:   v[i] = ((w % 2) == 0);
        default: v[i] = (c < m_duty[i]);
      endcase
    end
    return v;
  endfunction

  always @(negedge m_clock) begin
    if (chk_en) begin
      chk("led", 32'(led), 32'(exp_led()));
      chk("tick", 32'(tick), 32'((k % PRE_DIV) == PRE_DIV - 1 && p_reset));
      chk("cfg_ack", 32'(cfg.cfg_ack), 32'(m_ack));
      chk("cfg_err", 32'(cfg.cfg_err), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge m_clock);
    #2;
  endtask

  task automatic wr(input int a, input mode_t m, input int per, input int dty);
    cfg.cfg_we     = 1'b1;
    cfg.cfg_addr   = 2'(a);
    cfg.cfg_mode   = m;
    cfg.cfg_period = 8'(per);
    cfg.cfg_duty   = 8'(dty);
    cyc();
    cfg.cfg_we = 1'b0;
  endtask

  task automatic wait_bit(input int b, input logic v, input int maxc, output int cnt);
    cnt = 0;
    while (led[b] !== v && cnt < maxc) begin
      cyc();
      cnt++;
    end
  endtask

  task automatic blink_after_release(input string nm);
    int cnt, first_tick;
    cnt = 0;
    first_tick = -1;
    while (led == 3'b111 && cnt < 40) begin
      cyc();
      cnt++;
      if (tick && first_tick < 0) first_tick = cnt;
    end
    chk({nm, "_first_tick"}, 32'(first_tick), 32'd3);
    chk({nm, "_first_toggle"}, 32'(cnt), 32'd16);
    chk({nm, "_led_low"}, 32'(led), 32'd0);
    cnt = 0;
    while (led == 3'b000 && cnt < 40) begin
      cyc();
      cnt++;
    end
    chk({nm, "_second_toggle"}, 32'(cnt), 32'd16);
  endtask

  initial begin
    int cnt, hi, lo, ones;
    p_reset = 1'b0;
    cfg.cfg_we = 1'b0;
    cfg.cfg_addr = '0;
    cfg.cfg_mode = OFF;
    cfg.cfg_period = '0;
    cfg.cfg_duty = '0;

    repeat (3) cyc();
    chk_en = 1'b1;
    chk("rst_led", 32'(led), 32'b111);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_ack", 32'(cfg.cfg_ack), 32'd0);
    p_reset = 1'b1;
    blink_after_release("rel");

    // PWM on ch1: 3 of 10 ticks high at 4 clocks per tick
    wr(1, PWM, 9, 3);
    chk("pwm_ack", 32'(cfg.cfg_ack), 32'd1);
    wait_bit(1, 1'b0, 60, cnt);
    wait_bit(1, 1'b1, 60, cnt);
    wait_bit(1, 1'b0, 60, hi);
    wait_bit(1, 1'b1, 60, lo);
    chk("pwm_high", 32'(hi), 32'd12);
    chk("pwm_low", 32'(lo), 32'd28);

    wr(1, PWM, 9, 0);
    ones = 0;
    repeat (50) begin cyc(); ones += int'(led[1]); end
    chk("pwm_duty0_ones", 32'(ones), 32'd0);
    wr(1, PWM, 9, 12);
    ones = 0;
    repeat (50) begin cyc(); ones += int'(led[1]); end
    chk("pwm_duty_gt_ones", 32'(ones), 32'd50);

    // BLINK with period 0 wraps on every tick
    wr(2, BLINK, 0, 0);
    wait_bit(2, 1'b0, 20, cnt);
    wait_bit(2, 1'b1, 20, cnt);
    chk("blink_p0_interval", 32'(cnt), 32'd4);
    cnt = 0;
    while (!tick && cnt < 10) begin cyc(); cnt++; end
    wr(2, ON, 0, 0);
    chk("wr_on_wrap_led", 32'(led[2]), 32'd1);
    cnt = 0;
    while (!tick && cnt < 10) begin cyc(); cnt++; end
    wr(2, BLINK, 0, 0);
    chk("wr_blink_wrap_notoggle", 32'(led[2]), 32'd1);

    wr(3, ON, 1, 1);
    chk("bad_addr_err", 32'(cfg.cfg_err), 32'd1);
    chk("bad_addr_ack", 32'(cfg.cfg_ack), 32'd0);

    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg.cfg_we     = 1'b1;
        cfg.cfg_addr   = 2'($urandom_range(0, 3));
        cfg.cfg_mode   = mode_t'(2'($urandom_range(0, 3)));
        cfg.cfg_period = 8'($urandom_range(0, 7));
        cfg.cfg_duty   = 8'($urandom_range(0, 9));
      end else begin
        cfg.cfg_we = 1'b0;
      end
      cyc();
    end
    cfg.cfg_we = 1'b0;

    wr(0, PWM, 5, 2);
    wr(1, OFF, 0, 0);
    repeat (7) cyc();
    p_reset = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'b111);
    repeat (2) cyc();
    p_reset = 1'b1;
    blink_after_release("rerel");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/led_blink_bank.md
LED_BLINK_BANK -- requirements
Module: led_blink_bank

Interface
REQ-001 SHALL have parameter CH, default 4, number of LED channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 24, per-channel counter, period and duty width.
REQ-003 SHALL have parameter PRE_DIV, default 1, prescaler divide ratio in m_clock cycles (>=1).
REQ-004 SHALL have parameter RST_PERIOD, default 2^23-1, reset value of every channel period.
REQ-005 SHALL have parameter RST_MODE, default BLINK, reset value of every channel mode.
REQ-006 SHALL have port m_clock, input, 1, clock; all state is updated on its rising edge.
REQ-007 SHALL have port p_reset, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port cfg_we, input, 1, configuration write strobe, one cycle per write.
REQ-009 SHALL have port cfg_addr, input, AW = max(1, clog2(CH)), target channel.
REQ-010 SHALL have port cfg_mode, input, 2, encoding OFF=0, ON=1, BLINK=2, PWM=3.
REQ-011 SHALL have port cfg_period, input, CNT_W, period value; effective period is value+1 ticks.
REQ-012 SHALL have port cfg_duty, input, CNT_W, PWM high time in ticks.
REQ-013 SHALL have port cfg_ack, output, 1, one-cycle pulse for an accepted write.
REQ-014 SHALL have port cfg_err, output, 1, one-cycle pulse for a rejected write.
REQ-015 SHALL have port tick, output, 1, prescaler strobe.
REQ-016 SHALL have port led, output, CH, LED drive; bit i belongs to channel i.

Function
REQ-017 Prescaler SHALL count 0..PRE_DIV-1 and wrap to 0. tick SHALL be high for exactly the cycle in which the count equals PRE_DIV-1. With PRE_DIV=1, tick SHALL be constantly high after reset.
REQ-018 Each channel counter SHALL advance only on tick. When it equals period, it SHALL wrap to 0 on that tick. With period=0 it SHALL stay at 0 and a wrap SHALL occur on every tick.
REQ-019 Each channel SHALL keep a blink-state bit that toggles on every wrap.
REQ-020 Channel mode behaviour SHALL be:
- OFF: led[i]=0.
- ON: led[i]=1.
- BLINK: led[i]=blink-state.
- PWM: led[i]=(cnt<duty), so duty=0 gives constant 0 and duty>period gives constant 1.
REQ-021 led SHALL be decoded from registers only, with no combinational path from any input.
REQ-022 On a clock edge with cfg_we=1 and cfg_addr<CH, the target channel SHALL load mode/period/duty, clear cnt to 0 and set blink-state to 1. cfg_ack SHALL be high in the following cycle.
REQ-023 With cfg_we=1 and cfg_addr>=CH, no state SHALL change and cfg_err SHALL be high in the following cycle.
REQ-024 When a write coincides with a tick wrap on the target channel, the write SHALL win: cnt=0, blink-state=1, no toggle.
REQ-025 Channels not addressed by a write SHALL be unaffected, and the prescaler SHALL never be reset by writes.
REQ-026 Mode changes SHALL take effect on led in the cycle after the write edge.

Reset
REQ-027 On p_reset low, independent of m_clock, the block SHALL set:
- prescaler=0;
- every cnt=0;
- blink-state=1;
- mode=RST_MODE, period=RST_PERIOD, duty=0;
- cfg_ack=0, cfg_err=0.
REQ-028 With RST_MODE=BLINK, led SHALL read all ones during and immediately after reset.
REQ-029 Reset asserted mid-operation SHALL discard all configuration and return to the REQ-027 state.

Structure
REQ-030 A package led_blink_pkg SHALL hold the mode type/encoding constants (OFF, ON, BLINK, PWM) and the AW width function.
REQ-031 Per-channel counter, blink-state, configuration registers and led decode SHALL be a sub-module led_blink_ch, instantiated CH times.
REQ-032 The prescaler and write decode SHALL live in led_blink_bank.

Verification (CH=3, CNT_W=8, PRE_DIV=4, RST_PERIOD=3, RST_MODE=BLINK)
REQ-033 Reset: p_reset low for 3 cycles -> led=3'b111, tick=0, cfg_ack=0. After release, tick pulses every 4 clocks and all led bits toggle every 16 clocks.
REQ-034 PWM: write ch1 mode=PWM, period=9, duty=3 -> cfg_ack 1 cycle later; led[1] high for 12 clocks, low for 28, repeating at 40 clocks.
REQ-035 PWM boundaries: ch1 duty=0 -> led[1] constantly 0; duty=12 with period=9 -> led[1] constantly 1.
REQ-036 BLINK period=0: ch2 mode=BLINK, period=0 -> led[2] toggles every 4 clocks. A write of mode=ON on the same edge as a wrap -> cnt=0, no toggle, led[2]=1 next cycle.
REQ-037 Bad address: write cfg_addr=3 -> cfg_err pulse, no cfg_ack, all channel state unchanged.
REQ-038 Reset mid-run: p_reset low while ch0 is PWM and ch1 is OFF -> led returns to 3'b111 asynchronously and the reset blink timing resumes.
